// File: rtl/note_sequencer_pkg.sv
// rtl/note_sequencer_pkg.sv - shared widths, ROM word layout and FSM encoding for note_sequencer
package note_sequencer_pkg;

    localparam int NOTE_W       = 6;
    localparam int DUR_W        = 6;
    localparam int SONG_W       = 2;
    localparam int ROM_W        = NOTE_W + DUR_W;
    localparam int ROM_DUR_LSB  = 0;
    localparam int ROM_NOTE_LSB = ROM_DUR_LSB + DUR_W;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  duration;
    } rom_word_t;

endpackage

// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - song ROM bus between note_sequencer and the external ROM
interface note_sequencer_if
    import note_sequencer_pkg::*;
#(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] rom_addr;
    logic [ROM_W-1:0]  rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/note_sequencer_duration_counter.sv
// rtl/note_sequencer_duration_counter.sv - beat down-counter holding the remaining length of a note
module duration_counter
    import note_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [DUR_W-1:0] load_value,
    input  logic             dec,
    output logic             last
);

    logic [DUR_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - {{(DUR_W-1){1'b0}}, 1'b1};
        end
    end

    assign last = (count == {{(DUR_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - walks a song in the external ROM, emitting one note per duration of beats
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int NOTE_IDX_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              play,
    input  logic              reset_player,
    input  logic [SONG_W-1:0] song,
    input  logic              beat,
    note_sequencer_if.master  rom,
    output logic [NOTE_W-1:0] note_out,
    output logic              new_note,
    output logic              song_done
);

    localparam logic [NOTE_IDX_W-1:0] LAST_IDX = '1;
    localparam logic [NOTE_IDX_W-1:0] ONE_IDX  = {{(NOTE_IDX_W-1){1'b0}}, 1'b1};

    logic [2:0]            state;
    logic [NOTE_IDX_W-1:0] note_idx;
    logic [SONG_W-1:0]     song_latched;
    rom_word_t             word;
    logic                  qual_beat;
    logic                  cnt_clear;
    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_last;

    assign word      = rom_word_t'(rom.rom_data);
    // A beat only counts while playing; paused beats are dropped, not deferred.
    assign qual_beat = beat & play;

    assign cnt_clear = reset_player | (state == ST_DONE);
    assign cnt_load  = !reset_player && (state == ST_LOAD) && (word.duration != '0);
    assign cnt_dec   = !reset_player && (state == ST_HOLD) && qual_beat;

    duration_counter u_duration_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .load_value (word.duration),
        .dec        (cnt_dec),
        .last       (cnt_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            note_idx     <= '0;
            song_latched <= '0;
            note_out     <= '0;
            new_note     <= 1'b0;
        end else begin
            new_note <= 1'b0;
            if (reset_player) begin
                state    <= ST_IDLE;
                note_idx <= '0;
                note_out <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        song_latched <= song;
                        note_idx     <= '0;
                        if (play) state <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        if (play) state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        // Zero duration marks the end of a song shorter than 32 notes.
                        if (word.duration == '0) begin
                            state <= ST_DONE;
                        end else begin
                            note_out <= word.note;
                            new_note <= 1'b1;
                            state    <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (qual_beat && cnt_last) begin
                            if (note_idx == LAST_IDX) begin
                                state <= ST_DONE;
                            end else begin
                                note_idx <= note_idx + ONE_IDX;
                                state    <= ST_FETCH;
                            end
                        end
                    end
                    ST_DONE: begin
                        note_out <= '0;
                        note_idx <= '0;
                        state    <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign song_done    = (state == ST_DONE);
    assign rom.rom_addr = {song_latched, note_idx};

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - randomized self-checking bench for note_sequencer against a song-level model
module tb_note_sequencer;
    import note_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       play;
    logic       reset_player;
    logic [1:0] song;
    logic       beat;
    logic [5:0] note_out;
    logic       new_note;
    logic       song_done;

    note_sequencer_if bus ();

    note_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .play         (play),
        .reset_player (reset_player),
        .song         (song),
        .beat         (beat),
        .rom          (bus.master),
        .note_out     (note_out),
        .new_note     (new_note),
        .song_done    (song_done)
    );

    logic [11:0] rom [0:127];

    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int checks = 0;
    int passed = 0;

    task automatic tick(input logic b, input logic p);
        beat = b;
        play = p;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(1'b0, 1'b0);
        checks++;
        if (note_out !== 6'd0 || new_note !== 1'b0 || song_done !== 1'b0 || bus.rom_addr !== 7'd0)
            $display("FAIL reset_outputs got note=%0d nn=%0b sd=%0b addr=%0d want all 0",
                     note_out, new_note, song_done, bus.rom_addr);
        else passed++;
        reset_n = 1'b1;
        tick(1'b0, 1'b0);
        checks++;
        if (note_out !== 6'd0 || new_note !== 1'b0 || song_done !== 1'b0 || bus.rom_addr !== 7'd0)
            $display("FAIL post_reset_idle got note=%0d nn=%0b sd=%0b addr=%0d want all 0",
                     note_out, new_note, song_done, bus.rom_addr);
        else passed++;
    endtask

    // Song-level model: expected notes are the ROM words up to the end marker or 32 entries,
    // and each note must stay on rom_addr for exactly its duration in played beats.
    task automatic run_song(input logic [1:0] s, input bit rnd);
        logic [5:0]  exp_note [$];
        logic [5:0]  exp_dur  [$];
        logic [6:0]  exp_addr [$];
        logic [11:0] w;
        logic [6:0]  hold_addr;
        logic [5:0]  hold_dur;
        logic [5:0]  e_n;
        logic [6:0]  e_a;
        bit          holding;
        bit          done;
        int          cnt;
        int          cyc;
        logic        b;
        logic        p;
        for (int i = 0; i < 32; i++) begin
            w = rom[{s, 5'(i)}];
            if (w[5:0] == 6'd0) break;
            exp_note.push_back(w[11:6]);
            exp_dur.push_back(w[5:0]);
            exp_addr.push_back({s, 5'(i)});
        end
        song = s;
        holding = 1'b0;
        done = 1'b0;
        cnt = 0;
        hold_addr = '0;
        hold_dur = '0;
        tick(1'b0, 1'b1);
        cyc = 0;
        while (!done && cyc < 20000) begin
            cyc++;
            if (holding && (song_done || bus.rom_addr != hold_addr)) begin
                checks++;
                if (cnt != int'(hold_dur))
                    $display("FAIL note_beats addr=%0d got=%0d want=%0d", hold_addr, cnt, hold_dur);
                else passed++;
                holding = 1'b0;
            end
            if (new_note) begin
                checks++;
                if (exp_note.size() == 0) begin
                    $display("FAIL extra_note got note=%0d addr=%0d want none", note_out, bus.rom_addr);
                end else begin
                    e_n = exp_note.pop_front();
                    e_a = exp_addr.pop_front();
                    hold_dur = exp_dur.pop_front();
                    if (note_out !== e_n || bus.rom_addr !== e_a)
                        $display("FAIL note_load got note=%0d addr=%0d want note=%0d addr=%0d",
                                 note_out, bus.rom_addr, e_n, e_a);
                    else passed++;
                    hold_addr = e_a;
                    holding = 1'b1;
                    cnt = 0;
                end
            end
            if (song_done) begin
                done = 1'b1;
                checks++;
                if (exp_note.size() != 0)
                    $display("FAIL song_length got missing=%0d want missing=0", exp_note.size());
                else passed++;
            end
            p = rnd ? ($urandom_range(3) != 0) : 1'b1;
            b = ($urandom_range(2) == 0);
            if (holding && b && p) cnt++;
            tick(b, done ? 1'b0 : p);
        end
        checks++;
        if (!done) $display("FAIL song_timeout got done=0 want done=1 song=%0d", s);
        else passed++;
        checks++;
        if (song_done !== 1'b0 || note_out !== 6'd0 || new_note !== 1'b0 || bus.rom_addr !== {s, 5'd0})
            $display("FAIL after_done got sd=%0b note=%0d nn=%0b addr=%0d want sd=0 note=0 nn=0 addr=%0d",
                     song_done, note_out, new_note, bus.rom_addr, {s, 5'd0});
        else passed++;
    endtask

    task automatic test_single_note;
        int lat;
        int guard;
        rom[64] = {6'd17, 6'd3};
        rom[65] = {6'd9, 6'd0};
        song = 2'd2;
        tick(1'b0, 1'b1);
        lat = 1;
        while (!new_note && lat < 10) begin
            tick(1'b0, 1'b1);
            lat++;
        end
        checks++;
        if (lat != 3 || note_out !== 6'd17)
            $display("FAIL first_note_latency got lat=%0d note=%0d want lat=3 note=17", lat, note_out);
        else passed++;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        checks++;
        if (bus.rom_addr !== 7'd64) $display("FAIL hold_after_2 got addr=%0d want 64", bus.rom_addr);
        else passed++;
        tick(1'b1, 1'b1);
        checks++;
        if (bus.rom_addr !== 7'd65) $display("FAIL advance_after_3 got addr=%0d want 65", bus.rom_addr);
        else passed++;
        guard = 0;
        while (!song_done && guard < 20) begin
            tick(1'b0, 1'b1);
            guard++;
        end
        checks++;
        if (!song_done) $display("FAIL single_done got sd=0 want sd=1");
        else passed++;
        tick(1'b0, 1'b0);
        checks++;
        if (song_done !== 1'b0 || note_out !== 6'd0)
            $display("FAIL single_done_pulse got sd=%0b note=%0d want sd=0 note=0", song_done, note_out);
        else passed++;
    endtask

    task automatic test_pause;
        int guard;
        rom[32] = {6'd5, 6'd4};
        rom[33] = {6'd6, 6'd1};
        rom[34] = 12'd0;
        song = 2'd1;
        tick(1'b0, 1'b1);
        guard = 0;
        while (!new_note && guard < 10) begin
            tick(1'b0, 1'b1);
            guard++;
        end
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
        end
        checks++;
        if (bus.rom_addr !== 7'd32) $display("FAIL pause_ignores_beats got addr=%0d want 32", bus.rom_addr);
        else passed++;
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        checks++;
        if (bus.rom_addr !== 7'd32) $display("FAIL pause_third_beat got addr=%0d want 32", bus.rom_addr);
        else passed++;
        tick(1'b1, 1'b1);
        checks++;
        if (bus.rom_addr !== 7'd33) $display("FAIL pause_fourth_beat got addr=%0d want 33", bus.rom_addr);
        else passed++;
        guard = 0;
        while (!song_done && guard < 50) begin
            tick(1'b1, 1'b1);
            guard++;
        end
        checks++;
        if (!song_done) $display("FAIL pause_song_done got sd=0 want sd=1");
        else passed++;
        tick(1'b0, 1'b0);
    endtask

    task automatic test_full_song;
        for (int i = 0; i < 32; i++) rom[i] = {6'(i + 1), 6'd1};
        run_song(2'd0, 1'b0);
    endtask

    task automatic test_reset_player;
        int guard;
        for (int i = 0; i < 32; i++) rom[96 + i] = {6'(i + 1), 6'd1};
        song = 2'd3;
        tick(1'b0, 1'b1);
        guard = 0;
        while (!(new_note && bus.rom_addr == 7'd105) && guard < 300) begin
            tick(1'b1, 1'b1);
            guard++;
        end
        checks++;
        if (!(new_note && bus.rom_addr == 7'd105 && note_out == 6'd10))
            $display("FAIL reach_index9 got addr=%0d note=%0d want addr=105 note=10", bus.rom_addr, note_out);
        else passed++;
        reset_player = 1'b1;
        tick(1'b1, 1'b1);
        reset_player = 1'b0;
        checks++;
        if (note_out !== 6'd0 || new_note !== 1'b0 || song_done !== 1'b0 || bus.rom_addr !== 7'd96)
            $display("FAIL reset_player got note=%0d nn=%0b sd=%0b addr=%0d want note=0 nn=0 sd=0 addr=96",
                     note_out, new_note, song_done, bus.rom_addr);
        else passed++;
        tick(1'b0, 1'b1);
        guard = 0;
        while (!new_note && guard < 10) begin
            tick(1'b0, 1'b1);
            guard++;
        end
        checks++;
        if (!new_note || bus.rom_addr !== 7'd96 || note_out !== 6'd1)
            $display("FAIL restart_from_zero got nn=%0b addr=%0d note=%0d want nn=1 addr=96 note=1",
                     new_note, bus.rom_addr, note_out);
        else passed++;
        reset_player = 1'b1;
        tick(1'b0, 1'b0);
        reset_player = 1'b0;
    endtask

    task automatic test_song_change;
        int  guard;
        bit  bad;
        rom[32] = {6'd7, 6'd2};
        rom[33] = {6'd8, 6'd2};
        rom[34] = 12'd0;
        song = 2'd1;
        tick(1'b0, 1'b1);
        guard = 0;
        while (!new_note && guard < 10) begin
            tick(1'b0, 1'b1);
            guard++;
        end
        song = 2'd3;
        bad = 1'b0;
        guard = 0;
        while (!song_done && guard < 50) begin
            if (bus.rom_addr[6:5] !== 2'd1) bad = 1'b1;
            tick(1'b1, 1'b1);
            guard++;
        end
        checks++;
        if (bad || !song_done) $display("FAIL song_held got bad=%0b sd=%0b want bad=0 sd=1", bad, song_done);
        else passed++;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if (bus.rom_addr !== 7'd96) $display("FAIL song_relatch got addr=%0d want 96", bus.rom_addr);
        else passed++;
    endtask

    task automatic test_async_reset;
        song = 2'd1;
        rom[32] = {6'd5, 6'd4};
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        play = 1'b0;
        #1;
        checks++;
        if (note_out !== 6'd0 || new_note !== 1'b0 || song_done !== 1'b0 || bus.rom_addr !== 7'd0)
            $display("FAIL async_reset got note=%0d nn=%0b sd=%0b addr=%0d want all 0",
                     note_out, new_note, song_done, bus.rom_addr);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (new_note !== 1'b0 || song_done !== 1'b0)
            $display("FAIL async_no_pulse got nn=%0b sd=%0b want nn=0 sd=0", new_note, song_done);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        tick(1'b0, 1'b0);
        checks++;
        if (bus.rom_addr !== 7'd32 || note_out !== 6'd0)
            $display("FAIL resume_idle got addr=%0d note=%0d want addr=32 note=0", bus.rom_addr, note_out);
        else passed++;
    endtask

    task automatic test_random;
        logic [1:0] s;
        int         d;
        for (int r = 0; r < 6; r++) begin
            s = 2'($urandom_range(3));
            for (int i = 0; i < 32; i++) begin
                d = ($urandom_range(15) == 0) ? 0 : int'($urandom_range(6, 1));
                rom[{s, 5'(i)}] = {6'($urandom_range(63)), 6'(d)};
            end
            run_song(s, 1'b1);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        play = 1'b0;
        beat = 1'b0;
        reset_player = 1'b0;
        song = 2'd0;
        for (int i = 0; i < 128; i++) rom[i] = 12'd0;
        @(negedge clk);
        test_reset();
        test_single_note();
        test_pause();
        test_full_song();
        test_reset_player();
        test_song_change();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
